oled_source_arbiter: RTL and testbench
======================================

OLED_SOURCE_ARBITER -- requirements
Module: oled_source_arbiter

Interface
REQ-001 Parameter N_SRC, default 4: number of pixel sources, range 2..8.
REQ-002 Parameter BLANK_COLOR, default 16'h0000: RGB565 value driven when no source owns the display.
REQ-003 Parameter BLANK_FRAMES, default 1: whole blank frames inserted between owner changes, range 1..15.
REQ-004 Parameter MIN_FRAMES, default 2: minimum frames an owner holds the grant while its request stays high, range 1..15.
REQ-005 clk  in  1  display pixel clock (6.25 MHz domain), rising edge.
REQ-006 reset  in  1  asynchronous, active-high.
REQ-007 frame_begin  in  1  one-cycle pulse from the display driver at the start of each frame.
REQ-008 req  in  N_SRC  per-source display request, level-sensitive.
REQ-009 pix_in  in  16*N_SRC  per-source pixel data; source i occupies bits [16*i+15:16*i].
REQ-010 oled_data  out  16  pixel data to the display driver.
REQ-011 grant  out  N_SRC  one-hot owner, or all zero.
REQ-012 active  out  1  high while state is OWN.
REQ-013 switch_pulse  out  1  one-cycle pulse when a new grant takes effect.

Function
REQ-014 The block SHALL implement three states: IDLE, BLANK and OWN.
REQ-015 State, grant, owner index and counters SHALL change only on a clk edge on which frame_begin is high, except switch_pulse clearing and reset.
REQ-016 Winner SHALL be the lowest-indexed asserted req bit, sampled on the frame_begin edge; no winner when req is all zero.
REQ-017 IDLE: on frame_begin with a winner -> BLANK with blank_cnt=BLANK_FRAMES-1; otherwise stay in IDLE.
REQ-018 BLANK: on frame_begin with blank_cnt>0 -> decrement blank_cnt; with blank_cnt=0 and a winner -> OWN, grant the winner, set hold_cnt=MIN_FRAMES-1 and pulse switch_pulse; with blank_cnt=0 and no winner -> IDLE.
REQ-019 OWN, on frame_begin: if the owner's req is low -> BLANK (blank_cnt=BLANK_FRAMES-1) and grant clears.
REQ-020 OWN, on frame_begin with owner req high and hold_cnt>0: stay in OWN and decrement hold_cnt, even if a higher-priority req is asserted.
REQ-021 OWN, on frame_begin with owner req high and hold_cnt=0: stay in OWN if winner equals the owner; otherwise -> BLANK and grant clears.
REQ-022 oled_data SHALL be combinational: the owner's pix_in slice in OWN, BLANK_COLOR in IDLE and BLANK, with no added latency relative to pix_in.
REQ-023 grant SHALL never have more than one bit set; grant is nonzero if and only if state is OWN.
REQ-024 switch_pulse SHALL be high exactly one clk cycle, on the cycle after the edge that enters OWN.
REQ-025 req changes between frame_begin pulses SHALL have no effect on any output.
REQ-026 All counters SHALL saturate at 0 and never wrap.
REQ-027 Back-to-back frame_begin pulses on consecutive cycles SHALL each be processed as a separate frame.

Reset
REQ-028 Asserting reset SHALL immediately force IDLE, grant=0, active=0, switch_pulse=0, oled_data=BLANK_COLOR, and all counters to 0, including in mid-frame or mid-BLANK.
REQ-029 After reset deasserts, the first arbitration decision SHALL occur on the next frame_begin.

Verification
REQ-030 req=4'b0100 held, defaults -> frame 1 BLANK; on frame 2 edge grant=4'b0100 and switch_pulse for 1 cycle; oled_data follows pix_in[47:32].
REQ-031 Source 2 owns the display and req[0] rises -> grant holds 4'b0100 for MIN_FRAMES=2 frame edges, then BLANK for 1 frame, then grant=4'b0001.
REQ-032 Owner req drops mid-frame -> grant stays until the next frame_begin, then grant=0 and oled_data=BLANK_COLOR; state goes to IDLE one frame later if req=0.
REQ-033 req pulses high and low entirely between two frame_begin pulses -> no output change.
REQ-034 reset asserted in OWN mid-frame -> same cycle grant=0 and oled_data=BLANK_COLOR; after release, no grant before the second frame_begin.
REQ-035 Random req plus frame_begin stimulus for 10k frames -> grant is always one-hot or zero, and every owner change is separated by at least BLANK_FRAMES blank frames.

Source files
------------

// File: rtl/oled_source_arbiter.sv
// Frame-synchronous arbiter that hands the OLED display to the lowest-indexed requesting source.
// Blank frames separate owners, and each new owner holds the display for a minimum number of frames.
module oled_source_arbiter #(
    parameter int unsigned N_SRC        = 4,
    parameter logic [15:0] BLANK_COLOR  = 16'h0000,
    parameter int unsigned BLANK_FRAMES = 1,
    parameter int unsigned MIN_FRAMES   = 2
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 frame_begin,
    input  logic [N_SRC-1:0]     req,
    input  logic [16*N_SRC-1:0]  pix_in,
    output logic [15:0]          oled_data,
    output logic [N_SRC-1:0]     grant,
    output logic                 active,
    output logic                 switch_pulse
);

    localparam int unsigned IdxW      = (N_SRC > 1) ? $clog2(N_SRC) : 1;
    localparam logic [3:0]  BlankInit = 4'(BLANK_FRAMES - 1);
    localparam logic [3:0]  HoldInit  = 4'(MIN_FRAMES - 1);

    typedef enum logic [1:0] {StIdle, StBlank, StOwn} state_e;

    state_e          state_q;
    logic [IdxW-1:0] owner_q;
    logic [3:0]      blank_cnt_q;
    logic [3:0]      hold_cnt_q;
    logic            win_found;
    logic [IdxW-1:0] win_idx;

    // Scan downward so that the lowest asserted index is the last one written.
    always_comb begin
        win_found = 1'b0;
        win_idx   = '0;
        for (int i = int'(N_SRC) - 1; i >= 0; i--) begin
            if (req[i]) begin
                win_found = 1'b1;
                win_idx   = IdxW'(i);
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q      <= StIdle;
            owner_q      <= '0;
            grant        <= '0;
            blank_cnt_q  <= '0;
            hold_cnt_q   <= '0;
            switch_pulse <= 1'b0;
        end else begin
            switch_pulse <= 1'b0;
            if (frame_begin) begin
                case (state_q)
                    StIdle: begin
                        if (win_found) begin
                            state_q     <= StBlank;
                            blank_cnt_q <= BlankInit;
                        end
                    end
                    StBlank: begin
                        if (blank_cnt_q != 4'd0) begin
                            blank_cnt_q <= blank_cnt_q - 4'd1;
                        end else if (win_found) begin
                            state_q      <= StOwn;
                            owner_q      <= win_idx;
                            grant        <= N_SRC'(1) << win_idx;
                            hold_cnt_q   <= HoldInit;
                            switch_pulse <= 1'b1;
                        end else begin
                            state_q <= StIdle;
                        end
                    end
                    StOwn: begin
                        // The owner yields when it drops its request, or once the hold has
                        // expired and it is no longer the priority winner.
                        if (!req[owner_q] || (hold_cnt_q == 4'd0 && win_idx != owner_q)) begin
                            state_q     <= StBlank;
                            grant       <= '0;
                            blank_cnt_q <= BlankInit;
                        end else if (hold_cnt_q != 4'd0) begin
                            hold_cnt_q <= hold_cnt_q - 4'd1;
                        end
                    end
                    default: state_q <= StIdle;
                endcase
            end
        end
    end

    assign active    = (state_q == StOwn);
    assign oled_data = (state_q == StOwn) ? pix_in[{owner_q, 4'b0000} +: 16] : BLANK_COLOR;

endmodule

// File: tb/tb_oled_source_arbiter.sv
// Scoreboard bench for oled_source_arbiter: directed frame sequences with queued expectations,
// followed by a random req/frame_begin soak that checks grant invariants.
module tb_oled_source_arbiter;

    localparam int unsigned N_SRC = 4;
    localparam int unsigned BF    = 1;

    typedef struct packed {
        logic [3:0]  g;
        logic        sp;
        logic        act;
        logic [15:0] d;
    } exp_t;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        frame_begin = 1'b0;
    logic [3:0]  req = '0;
    logic [63:0] pix_in = {16'h4444, 16'h3333, 16'h2222, 16'h1111};
    logic [15:0] oled_data;
    logic [3:0]  grant;
    logic        active;
    logic        switch_pulse;

    exp_t  exp_q[$];
    string name_q[$];
    int    checks = 0;
    int    fails = 0;
    event  chk_ev;

    oled_source_arbiter #(
        .N_SRC       (N_SRC),
        .BLANK_COLOR (16'h0000),
        .BLANK_FRAMES(BF),
        .MIN_FRAMES  (2)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .frame_begin (frame_begin),
        .req         (req),
        .pix_in      (pix_in),
        .oled_data   (oled_data),
        .grant       (grant),
        .active      (active),
        .switch_pulse(switch_pulse)
    );

    always #5 clk = ~clk;

    // Monitor: pops one expectation per negedge (or on demand) and compares.
    initial begin
        exp_t  e;
        string n;
        forever begin
            @(negedge clk or chk_ev);
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                n = name_q.pop_front();
                checks++;
                if ({grant, switch_pulse, active, oled_data} !== {e.g, e.sp, e.act, e.d}) begin
                    fails++;
                    $display("FAIL %s: got grant=%b sp=%b act=%b data=%h, want grant=%b sp=%b act=%b data=%h",
                             n, grant, switch_pulse, active, oled_data, e.g, e.sp, e.act, e.d);
                end
            end
        end
    end

    // Invariants checked every cycle: one-hot grant, grant tied to active, owner changes
    // only on frame edges and always separated by at least BF blank frames.
    initial begin
        logic [3:0] prev_g;
        logic       fb_at;
        int         zero_frames;
        prev_g      = '0;
        zero_frames = 0;
        forever begin
            @(posedge clk);
            fb_at = frame_begin;
            @(negedge clk);
            if (reset) begin
                prev_g      = '0;
                zero_frames = 0;
            end else begin
                checks++;
                if (!$onehot0(grant) || ((grant != 4'd0) != active)) begin
                    fails++;
                    $display("FAIL grant_invariant: got grant=%b active=%b, want onehot0 and active==|grant",
                             grant, active);
                end
                checks++;
                if (!fb_at && grant != prev_g) begin
                    fails++;
                    $display("FAIL grant_off_frame: got grant=%b, want %b (no frame_begin)",
                             grant, prev_g);
                end else if (fb_at && grant != 4'd0 && prev_g != 4'd0 && grant != prev_g) begin
                    fails++;
                    $display("FAIL direct_switch: got grant=%b after %b, want a blank frame between",
                             grant, prev_g);
                end
                if (fb_at) begin
                    if (prev_g != 4'd0 && grant == 4'd0) zero_frames = 0;
                    else if (prev_g == 4'd0) zero_frames++;
                    if (prev_g == 4'd0 && grant != 4'd0) begin
                        checks++;
                        if (zero_frames < int'(BF)) begin
                            fails++;
                            $display("FAIL blank_gap: got %0d blank frames, want at least %0d",
                                     zero_frames, BF);
                        end
                    end
                end
                prev_g = grant;
            end
        end
    end

    task automatic expect_now(input logic [3:0] g, input logic sp, input logic act,
                              input logic [15:0] d, input string n);
        exp_t e;
        e = '{g: g, sp: sp, act: act, d: d};
        exp_q.push_back(e);
        name_q.push_back(n);
    endtask

    // One clock: drive inputs, then queue the expected outputs after the edge.
    task automatic cyc(input logic fb, input logic [3:0] r, input logic [3:0] g, input logic sp,
                       input logic [15:0] d, input string n);
        frame_begin = fb;
        req         = r;
        @(posedge clk);
        #1;
        expect_now(g, sp, (g != 4'd0), d, n);
        @(negedge clk);
        #1;
    endtask

    initial begin
        expect_now(4'b0000, 1'b0, 1'b0, 16'h0000, "reset_state");
        @(negedge clk);
        #1;
        reset = 1'b0;

        // Single source 2 request: one blank frame, then grant.
        cyc(1'b0, 4'b0100, 4'b0000, 1'b0, 16'h0000, "idle_no_frame");
        cyc(1'b1, 4'b0100, 4'b0000, 1'b0, 16'h0000, "idle_to_blank");
        cyc(1'b0, 4'b0100, 4'b0000, 1'b0, 16'h0000, "blank_hold");
        cyc(1'b1, 4'b0100, 4'b0100, 1'b1, 16'h3333, "own_src2_enter");
        cyc(1'b0, 4'b0100, 4'b0100, 1'b0, 16'h3333, "own_src2_pulse_clear");
        pix_in[47:32] = 16'h5a5a;
        cyc(1'b0, 4'b0100, 4'b0100, 1'b0, 16'h5a5a, "own_src2_pix_follow");

        // Higher-priority request while the hold runs.
        cyc(1'b1, 4'b0101, 4'b0100, 1'b0, 16'h5a5a, "hold_ignores_prio");
        cyc(1'b0, 4'b0101, 4'b0100, 1'b0, 16'h5a5a, "hold_mid_frame");
        cyc(1'b1, 4'b0101, 4'b0000, 1'b0, 16'h0000, "preempt_to_blank");
        cyc(1'b1, 4'b0101, 4'b0001, 1'b1, 16'h1111, "b2b_frame_own_src0");
        cyc(1'b0, 4'b0101, 4'b0001, 1'b0, 16'h1111, "own_src0");

        // Owner drops its request between frames.
        cyc(1'b0, 4'b0100, 4'b0001, 1'b0, 16'h1111, "drop_mid_frame_a");
        cyc(1'b0, 4'b0000, 4'b0001, 1'b0, 16'h1111, "drop_mid_frame_b");
        cyc(1'b1, 4'b0000, 4'b0000, 1'b0, 16'h0000, "drop_to_blank");
        cyc(1'b1, 4'b0000, 4'b0000, 1'b0, 16'h0000, "blank_to_idle");

        // A request pulse entirely between frames leaves no trace.
        cyc(1'b0, 4'b1000, 4'b0000, 1'b0, 16'h0000, "glitch_req_a");
        cyc(1'b0, 4'b0000, 4'b0000, 1'b0, 16'h0000, "glitch_req_b");
        cyc(1'b1, 4'b0000, 4'b0000, 1'b0, 16'h0000, "glitch_frame1");
        cyc(1'b1, 4'b0000, 4'b0000, 1'b0, 16'h0000, "glitch_frame2");

        // Source 3 owns; at hold expiry it keeps ownership while it is the winner.
        cyc(1'b1, 4'b1000, 4'b0000, 1'b0, 16'h0000, "src3_blank");
        cyc(1'b1, 4'b1000, 4'b1000, 1'b1, 16'h4444, "src3_own");
        cyc(1'b1, 4'b1001, 4'b1000, 1'b0, 16'h4444, "src3_hold");
        cyc(1'b1, 4'b1000, 4'b1000, 1'b0, 16'h4444, "src3_keep_a");
        cyc(1'b1, 4'b1000, 4'b1000, 1'b0, 16'h4444, "src3_keep_b");
        cyc(1'b1, 4'b1001, 4'b0000, 1'b0, 16'h0000, "src3_preempt");
        cyc(1'b1, 4'b1001, 4'b0001, 1'b1, 16'h1111, "src0_own");
        cyc(1'b0, 4'b0001, 4'b0001, 1'b0, 16'h1111, "src0_mid_frame");

        // Asynchronous reset mid-frame in OWN.
        reset = 1'b1;
        #1;
        expect_now(4'b0000, 1'b0, 1'b0, 16'h0000, "reset_async");
        ->chk_ev;
        @(negedge clk);
        #1;
        reset = 1'b0;
        cyc(1'b0, 4'b0001, 4'b0000, 1'b0, 16'h0000, "post_reset_idle");
        cyc(1'b1, 4'b0001, 4'b0000, 1'b0, 16'h0000, "post_reset_frame1");
        cyc(1'b1, 4'b0001, 4'b0001, 1'b1, 16'h1111, "post_reset_frame2");

        // Random soak, checked by the invariant process.
        for (int f = 0; f < 10000; f++) begin
            int gap;
            gap = $urandom_range(0, 2);
            for (int k = 0; k < gap; k++) begin
                frame_begin = 1'b0;
                req         = 4'($urandom_range(0, 15));
                @(negedge clk);
                #1;
            end
            frame_begin = 1'b1;
            req         = ($urandom_range(0, 3) == 0) ? 4'd0 : 4'($urandom_range(0, 15));
            pix_in      = {$urandom, $urandom};
            @(negedge clk);
            #1;
        end
        frame_begin = 1'b0;

        for (int t = 0; t < 10 && exp_q.size() > 0; t++) @(negedge clk);
        if (exp_q.size() > 0) begin
            fails++;
            $display("FAIL scoreboard_drain: got %0d pending entries, want 0", exp_q.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule
